// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op-class helpers for the alu_mdu execute unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic is_mdu_op(input alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input alu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input alu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input alu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: magnitude conversion, XLEN shift-add or
// restoring steps into a shared 2*XLEN accumulator, then a combinational sign fix.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic            early,
  output logic [XLEN-1:0] early_result,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic              sa, sb;
  logic [XLEN-1:0]   ma, mb;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [XLEN-1:0]   opnd, addend, q_mag, r_mag, quo, rem;
  logic [XLEN:0]     sum, shifted, diff;
  logic [CW-1:0]     cnt;
  logic              div_q, hi_q, neg_q, neg_r;

  assign sa = is_signed_a(op) & a[XLEN-1];
  assign sb = is_signed_b(op) & b[XLEN-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  always_comb begin
    early        = 1'b0;
    early_result = '0;
    if (is_div_op(op)) begin
      if (b == '0) begin
        early        = 1'b1;
        early_result = is_rem_op(op) ? a : '1;
      end else if (is_signed_a(op) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
        early        = 1'b1;
        early_result = is_rem_op(op) ? '0 : a;
      end
    end
  end

  // Multiply keeps the multiplier in the low half and shifts right; divide keeps
  // the remainder high and the dividend/quotient low and shifts left.
  always_comb begin
    addend  = acc[0] ? opnd : '0;
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (!div_q)
      acc_next = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(XLEN);
      div_q <= is_div_op(op);
      hi_q  <= is_div_op(op) ? is_rem_op(op) : (op != OP_MUL);
      neg_q <= sa ^ sb;
      neg_r <= sa;
      acc   <= is_div_op(op) ? {{XLEN{1'b0}}, ma} : {{XLEN{1'b0}}, mb};
      opnd  <= is_div_op(op) ? mb : ma;
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
    end
  end

  assign q_mag = acc[XLEN-1:0];
  assign r_mag = acc[2*XLEN-1:XLEN];
  assign prod  = neg_q ? -acc : acc;
  assign quo   = neg_q ? -q_mag : q_mag;
  assign rem   = neg_r ? -r_mag : r_mag;

  always_comb begin
    if (div_q)
      result = hi_q ? rem : quo;
    else
      result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_mdu.sv
// Handshaked execute unit: 1-cycle RV32I ALU plus the iterative MDU, with
// IDLE/BUSY/DONE control, registered outputs and flush.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int M_EXT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          state, state_next;
  logic            accept, mdu_op, iter, start;
  logic            mdu_done, mdu_early;
  logic [XLEN-1:0] mdu_early_res, mdu_res, alu_res;
  logic            alu_ill;
  logic [SHW-1:0]  shamt;

  assign in_ready = !flush && (state == ST_IDLE || (state == ST_DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign mdu_op   = is_mdu_op(in_op);
  assign iter     = (M_EXT != 0) && mdu_op && !mdu_early;
  assign start    = accept && iter;
  assign shamt    = in_b[SHW-1:0];
  assign busy     = (state != ST_IDLE);

  generate
    if (M_EXT != 0) begin : g_mdu
      mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (in_op),
        .a            (in_a),
        .b            (in_b),
        .done         (mdu_done),
        .early        (mdu_early),
        .early_result (mdu_early_res),
        .result       (mdu_res)
      );
    end else begin : g_no_mdu
      assign mdu_done      = 1'b0;
      assign mdu_early     = 1'b0;
      assign mdu_early_res = '0;
      assign mdu_res       = '0;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      OP_ADD:    alu_res = in_a + in_b;
      OP_SUB:    alu_res = in_a - in_b;
      OP_AND:    alu_res = in_a & in_b;
      OP_OR:     alu_res = in_a | in_b;
      OP_XOR:    alu_res = in_a ^ in_b;
      OP_SLL:    alu_res = in_a << shamt;
      OP_SRL:    alu_res = in_a >> shamt;
      OP_SRA:    alu_res = $signed(in_a) >>> shamt;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      OP_PASS_B: alu_res = in_b;
      default: begin
        // M ops reaching here are either early-out divides or unimplemented.
        if (mdu_op && M_EXT != 0)
          alu_res = mdu_early_res;
        else
          alu_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mdu_done) state_next = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_next = iter ? ST_BUSY : ST_DONE;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= !iter;
      out_tag     <= in_tag;
      out_illegal <= iter ? 1'b0 : alu_ill;
      if (!iter) out_result <= alu_res;
    end else if (state == ST_BUSY && mdu_done) begin
      out_valid  <= 1'b1;
      out_result <= mdu_res;
    end else if (state == ST_DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed plus randomized bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  alu_op_e     in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        in_ready, out_valid, out_illegal, busy;

  logic        in_valid8, in_ready8, out_valid8, out_illegal8, busy8;
  alu_op_e     in_op8;
  logic [7:0]  in_a8, in_b8, out_result8;
  logic [4:0]  in_tag8, out_tag8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32), .TAG_W(5), .M_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
  );

  alu_mdu #(.XLEN(8), .TAG_W(5), .M_EXT(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op8), .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_result(out_result8),
    .out_tag(out_tag8), .out_illegal(out_illegal8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the RV32IM rules.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill, output logic it);
    longint      sa, sb, sp;
    logic [63:0] up;
    logic        ovf, dz;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = (b == 32'h0);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'h0; ill = 1'b0; it = 1'b0;
    case (op)
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLL:    r = a << b[4:0];
      OP_SRL:    r = a >> b[4:0];
      OP_SRA:    begin sp = sa >>> b[4:0]; r = sp[31:0]; end
      OP_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
      OP_PASS_B: r = b;
      OP_MUL:    begin sp = sa * sb; r = sp[31:0]; it = 1'b1; end
      OP_MULH:   begin sp = sa * sb; r = sp[63:32]; it = 1'b1; end
      OP_MULHSU: begin sp = sa * longint'({32'h0, b}); r = sp[63:32]; it = 1'b1; end
      OP_MULHU:  begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; it = 1'b1; end
      OP_DIV:    begin
        if (dz) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin sp = sa / sb; r = sp[31:0]; it = 1'b1; end
      end
      OP_REM:    begin
        if (dz) r = a;
        else if (ovf) r = 32'h0;
        else begin sp = sa % sb; r = sp[31:0]; it = 1'b1; end
      end
      OP_DIVU:   begin if (dz) r = 32'hFFFF_FFFF; else begin r = a / b; it = 1'b1; end end
      OP_REMU:   begin if (dz) r = a; else begin r = a % b; it = 1'b1; end end
      default:   begin r = 32'h0; ill = 1'b1; end
    endcase
  endfunction

  // Drive one op, wait for accept, then count edges after the accepting edge until out_valid.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int edges, output logic busy_ok);
    int k;
    @(negedge clk);
    in_op = alu_op_e'(op); in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    if (!in_ready) chk("accept_wait", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0; busy_ok = 1'b1;
    while (!out_valid && edges < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_check(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
    logic [31:0] er;
    logic        eill, eit, bok;
    int          edges;
    ref_model(op, a, b, er, eill, eit);
    issue(op, a, b, tag, edges, bok);
    chk({name, "_lat"}, 64'(edges), eit ? 64'd33 : 64'd0);
    chk({name, "_res"}, {32'h0, out_result}, {32'h0, er});
    chk({name, "_tag"}, {59'h0, out_tag}, {59'h0, tag});
    chk({name, "_ill"}, {63'h0, out_illegal}, {63'h0, eill});
    if (eit) chk({name, "_busy"}, {63'h0, bok}, 64'h1);
  endtask

  task automatic run8(input string name, input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic eill);
    @(negedge clk);
    in_op8 = op; in_a8 = a; in_b8 = b; in_tag8 = 5'd9; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk({name, "_vld"}, {63'h0, out_valid8}, 64'h1);
    chk({name, "_res"}, {56'h0, out_result8}, {56'h0, er});
    chk({name, "_ill"}, {63'h0, out_illegal8}, {63'h0, eill});
  endtask

  initial begin
    logic [31:0] er, hold_res, ra, rb;
    logic [4:0]  hold_tag, rop;
    logic        eill, eit, bok, saw;
    int          edges;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_ADD; in_a = '0; in_b = '0; in_tag = '0;
    in_valid8 = 1'b0; in_op8 = OP_ADD; in_a8 = '0; in_b8 = '0; in_tag8 = '0;
    #12;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_result", {32'h0, out_result}, 64'h0);
    chk("rst_tag_ill_busy", {57'h0, out_tag, out_illegal, busy}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'h0, in_ready}, 64'h1);

    run_check("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3);
    run_check("sra", OP_SRA, 32'h8000_0000, 32'h21, 5'd4);
    chk("sra_const", {32'h0, out_result}, 64'hC000_0000);
    run_check("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd5);
    chk("mulh_const", {32'h0, out_result}, 64'h4000_0000);
    run_check("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_check("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
    chk("div_neg_const", {32'h0, out_result}, 64'hFFFF_FFFD);
    run_check("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run_check("divu_zero", OP_DIVU, 32'd100, 32'd0, 5'd9);
    run_check("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_check("illegal", 5'd27, 32'h1234, 32'h5678, 5'd11);

    // Back-to-back single-cycle ops at one per cycle.
    @(negedge clk);
    in_op = OP_ADD; in_a = 32'd10; in_b = 32'd30; in_tag = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_vld", {63'h0, out_valid}, 64'h1);
      chk("b2b_res", {32'h0, out_result}, 64'(32'd10 + 32'(i) + 32'd30 * 32'(i + 1)));
      in_a = in_a + 32'd1; in_b = in_b + 32'd30;
      if (i == 3) in_valid = 1'b0;
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 50; i++) begin
      rop = 5'($urandom_range(0, 23));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($signed(8'($urandom))); rb = 32'($signed(4'($urandom))); end
        default: ;
      endcase
      run_check("rand", rop, ra, rb, 5'($urandom));
    end

    // Backpressure on an iterative result, then release with a new accept.
    @(posedge clk); #1;
    out_ready = 1'b0;
    ref_model(OP_DIVU, 32'd1000, 32'd7, er, eill, eit);
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd21, edges, bok);
    chk("bp_lat", 64'(edges), 64'd33);
    hold_res = out_result; hold_tag = out_tag;
    chk("bp_res", {32'h0, hold_res}, {32'h0, er});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", {32'h0, out_result}, {32'h0, er});
      chk("bp_hold_tag", {59'h0, out_tag}, 64'd21);
      chk("bp_hold_vld_rdy", {62'h0, out_valid, in_ready}, 64'h2);
    end
    @(negedge clk);
    out_ready = 1'b1; in_op = OP_SUB; in_a = 32'd50; in_b = 32'd8; in_tag = 5'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_release_res", {32'h0, out_result}, 64'd42);
    chk("bp_release_tag", {58'h0, out_valid, out_tag}, {58'h0, 1'b1, 5'd22});

    // Flush mid-divide with a competing in_valid.
    @(negedge clk);
    in_op = OP_DIV; in_a = 32'd12345; in_b = 32'd17; in_tag = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
    #1 chk("flush_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {62'h0, busy, out_valid}, 64'h0);
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    chk("flush_no_out", {63'h0, saw}, 64'h0);
    run_check("post_flush_add", OP_ADD, 32'd5, 32'd6, 5'd13);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    in_op = OP_MUL; in_a = 32'd1234; in_b = 32'd5678; in_tag = 5'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld_busy", {62'h0, out_valid, busy}, 64'h0);
    chk("midrst_res", {32'h0, out_result}, 64'h0);
    chk("midrst_tag_ill", {58'h0, out_tag, out_illegal}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {63'h0, in_ready}, 64'h1);

    // XLEN=8 without M extension.
    run8("x8_mul", OP_MUL, 8'h12, 8'h34, 8'h00, 1'b1);
    run8("x8_add", OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0);
    run8("x8_sra", OP_SRA, 8'h80, 8'h09, 8'hC0, 1'b0);
    run8("x8_divu", OP_DIVU, 8'h40, 8'h03, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
